// File: rtl/call_request_queue_if.sv
// Button inputs and request-FIFO handshake between the call-button panel and the
// downstream elevator controller.
interface call_request_queue_if;
  logic [5:0] f;
  logic [9:0] du;
  logic       clr;
  logic       req_ready;
  logic [2:0] req_floor;
  logic       req_valid;
  logic [5:0] pending;
  logic [2:0] count;
  logic       full;

  modport master (
    output f, du, clr, req_ready,
    input  req_floor, req_valid, pending, count, full
  );

  modport slave (
    input  f, du, clr, req_ready,
    output req_floor, req_valid, pending, count, full
  );
endinterface

// File: rtl/call_request_queue.sv
// Edge-detects cabin and hall calls, de-duplicates them per floor and queues them
// in arrival order (lowest floor first within one cycle) for the controller.
module call_request_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  call_request_queue_if.slave  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  logic [5:0]       hit, hit_q, rise, accept;
  logic [5:0]       stage_q, stage_d;
  logic [5:0]       fifo_bits, push_bit, pop_bit;
  logic             arm_q;
  logic [2:0]       mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  ptr_t             rd_q, wr_q;
  logic [2:0]       count_q;
  logic [2:0]       push_floor;
  logic             push, pop;

  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // U6 and D1 do not exist.
  always_comb begin
    hit[0] = bus.f[0] | bus.du[0];
    hit[1] = bus.f[1] | bus.du[1] | bus.du[5];
    hit[2] = bus.f[2] | bus.du[2] | bus.du[6];
    hit[3] = bus.f[3] | bus.du[3] | bus.du[7];
    hit[4] = bus.f[4] | bus.du[4] | bus.du[8];
    hit[5] = bus.f[5] | bus.du[9];
  end

  // arm_q masks the first cycle after reset so buttons held through reset are not edges.
  assign rise = hit & ~hit_q & {6{arm_q}};

  always_comb begin
    fifo_bits = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i]) fifo_bits = fifo_bits | (6'b1 << (mem_q[i] - 3'd1));
    end
  end

  assign bus.pending   = stage_q | fifo_bits;
  assign bus.count     = count_q;
  assign bus.req_valid = (count_q != 3'd0);
  assign bus.full      = (count_q == 3'(DEPTH));
  assign bus.req_floor = vld_q[rd_q] ? mem_q[rd_q] : 3'd0;

  assign pop     = bus.req_valid & bus.req_ready & ~bus.clr;
  assign pop_bit = pop ? (6'b1 << (bus.req_floor - 3'd1)) : 6'b0;

  always_comb begin
    push_floor = 3'd0;
    push_bit   = 6'b0;
    for (int i = 5; i >= 0; i--) begin
      if (stage_q[i]) begin
        push_floor = 3'(i + 1);
        push_bit   = 6'b1 << i;
      end
    end
  end

  assign push = (|stage_q) & (~bus.full | pop) & ~bus.clr;

  // A floor leaving the FIFO this cycle may be re-requested in the same cycle.
  assign accept = rise & ~(bus.pending & ~pop_bit);

  always_comb begin
    stage_d = '0;
    if (!bus.clr) stage_d = (stage_q & ~(push ? push_bit : 6'b0)) | accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= '0;
      arm_q   <= 1'b0;
      stage_q <= '0;
      vld_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      hit_q   <= hit;
      arm_q   <= 1'b1;
      stage_q <= stage_d;
      if (bus.clr) begin
        vld_q   <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (pop) begin
          vld_q[rd_q] <= 1'b0;
          rd_q        <= ptr_next(rd_q);
        end
        // Set after the pop clear so a full-queue push+pop on the same slot keeps it valid.
        if (push) begin
          vld_q[wr_q] <= 1'b1;
          mem_q[wr_q] <= push_floor;
          wr_q        <= ptr_next(wr_q);
        end
        if (push && !pop)      count_q <= count_q + 3'd1;
        else if (pop && !push) count_q <= count_q - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_call_request_queue.sv
// Scoreboard bench: expected floors are queued as calls are made and compared
// against the head as the bench pops the DUT.
module tb_call_request_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_q[$];

  call_request_queue_if bus ();

  call_request_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, " count"}, int'(bus.count), 0);
    check_eq({tag, " valid"}, int'(bus.req_valid), 0);
    check_eq({tag, " floor"}, int'(bus.req_floor), 0);
    check_eq({tag, " pending"}, int'(bus.pending), 0);
    check_eq({tag, " full"}, int'(bus.full), 0);
  endtask

  // Pop one entry and compare it against the scoreboard head.
  task automatic pop_one(input string tag);
    int w = 0;
    while (!bus.req_valid && w < 10) begin
      tick();
      w++;
    end
    if (exp_q.size() == 0) begin
      check_eq({tag, " unexpected entry"}, int'(bus.req_floor), 0);
    end else begin
      check_eq({tag, " head"}, int'(bus.req_floor), exp_q.pop_front());
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) pop_one(tag);
    tick(2);
    check_empty({tag, " drained"});
  endtask

  initial begin
    bus.f = '0;
    bus.du = '0;
    bus.clr = 1'b0;
    bus.req_ready = 1'b0;

    tick(2);
    check_empty("reset");
    rst = 1'b0;
    tick();

    // Single press, two-edge latency.
    bus.f = 6'b100000;
    tick();
    bus.f = '0;
    check_eq("single latency valid", int'(bus.req_valid), 0);
    check_eq("single staged pending", int'(bus.pending), 6'b100000);
    tick();
    check_eq("single valid", int'(bus.req_valid), 1);
    check_eq("single pending", int'(bus.pending), 6'b100000);
    exp_q.push_back(6);
    drain("single");

    // Pop request with empty queue is ignored.
    bus.req_ready = 1'b1;
    tick(2);
    bus.req_ready = 1'b0;
    check_empty("underflow");

    // Order and de-dup: F6, U3, F3.
    bus.f = 6'b100000; tick(); bus.f = '0; tick();
    bus.du = 10'b0000000100; tick(); bus.du = '0; tick();
    bus.f = 6'b000100; tick(); bus.f = '0; tick(3);
    check_eq("dedup count", int'(bus.count), 2);
    check_eq("dedup pending", int'(bus.pending), 6'b100100);
    exp_q.push_back(6);
    exp_q.push_back(3);
    drain("dedup");

    // Simultaneous calls enqueue lowest first, one per edge.
    bus.f = 6'b010101; tick(); bus.f = '0;
    tick(); check_eq("simul c1", int'(bus.count), 1);
    check_eq("simul head", int'(bus.req_floor), 1);
    tick(); check_eq("simul c2", int'(bus.count), 2);
    tick(); check_eq("simul c3", int'(bus.count), 3);
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5);
    drain("simul");

    // Hall calls D6 and D2 map to floors 6 and 2.
    bus.du = 10'b1000100000; tick(); bus.du = '0; tick(3);
    check_eq("hall pending", int'(bus.pending), 6'b100010);
    exp_q.push_back(2); exp_q.push_back(6);
    drain("hall");

    // Full queue with overflow held in staging.
    bus.f = 6'b111111; tick(); bus.f = '0; tick(5);
    check_eq("full count", int'(bus.count), 4);
    check_eq("full flag", int'(bus.full), 1);
    check_eq("full pending", int'(bus.pending), 6'b111111);
    for (int i = 1; i <= 6; i++) exp_q.push_back(i);
    pop_one("full pop1");
    check_eq("push+pop count", int'(bus.count), 4);
    check_eq("push+pop full", int'(bus.full), 1);
    check_eq("push+pop pending", int'(bus.pending), 6'b111110);
    drain("full");

    // Re-press of the floor being popped in the same cycle is re-queued.
    bus.f = 6'b000010; tick(); bus.f = '0; tick(2);
    check_eq("repop head", int'(bus.req_floor), 2);
    bus.f = 6'b000010;
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.f = '0;
    check_eq("repop staged", int'(bus.pending), 6'b000010);
    tick();
    check_eq("repop count", int'(bus.count), 1);
    exp_q.push_back(2);
    drain("repop");

    // clr mid-fill; a press landing on the clr cycle is ignored and not re-seen.
    bus.f = 6'b000111; tick(); bus.f = '0; tick();
    check_eq("clr prefill", int'(bus.count), 1);
    bus.clr = 1'b1;
    bus.f = 6'b010000;
    bus.req_ready = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.req_ready = 1'b0;
    check_empty("clr");
    tick(3);
    check_empty("clr held");
    bus.f = '0;
    tick();

    // Async reset mid-operation with a button held across it.
    bus.f = 6'b001001; tick(); tick(2);
    check_eq("prerst count", int'(bus.count), 2);
    #2 rst = 1'b1;
    #1 check_empty("async rst");
    tick();
    rst = 1'b0;
    tick(4);
    check_empty("rst held");
    bus.f = '0; tick();
    bus.f = 6'b001000; tick(); bus.f = '0; tick();
    exp_q.push_back(4);
    drain("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule

// File: doc/call_request_queue.md
CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (legal range 2..6).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port f, input, 6 bits: cabin buttons; bit n-1 = floor n.
REQ-005 SHALL have port du, input, 10 bits: hall buttons, ordered [D6 D5 D4 D3 D2 U5 U4 U3 U2 U1].
REQ-006 SHALL have port clr, input, 1 bit: synchronous flush of all requests.
REQ-007 SHALL have port req_ready, input, 1 bit: the downstream controller has served the head floor.
REQ-008 SHALL have port req_floor, output, 3 bits: head floor, 1..6; 0 when empty.
REQ-009 SHALL have port req_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port pending, output, 6 bits: floors that are staged or queued; bit n-1 = floor n.
REQ-011 SHALL have port count, output, 3 bits: FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port full, output, 1 bit: count==DEPTH.

Function
REQ-013 SHALL form the per-floor call hit(n) = f[n-1] | U_n | D_n, where U6 and D1 are 0.
REQ-014 SHALL detect rising edges of hit(n) against a registered copy of hit, so a held button enqueues exactly once.
REQ-015 SHALL set staging bit n on a hit(n) edge only if pending[n-1] is 0; a duplicate edge is dropped.
REQ-016 SHALL move one staged floor per cycle into the FIFO tail, choosing the lowest-numbered staged floor, and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-017 SHALL keep staged floors in staging while the FIFO is full; no request is ever lost.
REQ-018 SHALL, on a cycle with req_valid=1 and req_ready=1, pop the head and clear its pending bit at that edge.
REQ-019 SHALL accept a push and a pop in the same cycle, including when full; count stays unchanged.
REQ-020 SHALL accept a new edge for the floor being popped in that same cycle as a new request, which is re-staged.
REQ-021 SHALL ignore req_ready when req_valid=0; this causes no underflow.
REQ-022 SHALL drive req_floor, req_valid, count and full from registers, with no combinational path from the inputs.
REQ-023 SHALL have a latency of 2 edges into an empty queue: edge at sample N stages the floor, edge N+1 enqueues it, and req_valid=1 after N+1.
REQ-024 SHALL define pending as the OR of the staging bits and the floor bits of all valid FIFO entries.
REQ-025 SHALL use FIFO pointers of width clog2(DEPTH) that wrap modulo DEPTH.
REQ-026 SHALL, when clr=1, empty the FIFO and staging and ignore edges that cycle, but still update the edge-detect register.
REQ-027 SHALL give clr priority over push and pop in the same cycle.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear the FIFO, pointers, staging and the edge-detect register.
REQ-029 SHALL hold these output values while rst=1: req_floor=0, req_valid=0, pending=0, count=0, full=0.
REQ-030 SHALL NOT treat a button already held when rst deasserts as an edge until it is released and pressed again.

Verification
REQ-031 Single press: pulse f[5] -> req_floor=6 and req_valid=1 two edges later; pending=6'b100000.
REQ-032 FIFO order and de-dup: press F6, then U3, then F3, with no pops -> count=2, head 6 then 3 after one pop; the F3 press is dropped.
REQ-033 Simultaneous calls: f=6'b010101 for one cycle -> floors 1, 3 and 5 enqueued on three consecutive edges in that order.
REQ-034 Full and staging: DEPTH=4, press all six floors, req_ready=0 -> count=4, full=1, pending=6'b111111; two pops enqueue floors 5 and 6.
REQ-035 Push+pop when full: pop on the same cycle a staged floor is pending -> count stays 4 and the new floor sits at the tail.
REQ-036 clr and reset: clr mid-fill, or rst asserted mid-operation -> all outputs 0 immediately (rst) or next edge (clr); a held button is not re-enqueued.
